sync_fifo_ctrl: RTL and testbench

Single-clock first-word-fall-through FIFO controller that owns the pointers, flags and read-prefetch logic for an external simple dual-port RAM. The RAM has a write port and a read port with one-cycle registered read data (`re` gated). This block sits directly upstream of the RAM: it generates all RAM address and enable strobes and presents the RAM read data to the consumer with a valid flag. The RAM's data register serves as the output stage, so RAM bypass logic is never required.

---
 rtl/sync_fifo_ctrl.sv | 95 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - FWFT FIFO controller driving an external registered-output dual-port RAM
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH+1:0] AFULL_V = (ADDR_WIDTH+2)'(AFULL_LEVEL);

    logic [ADDR_WIDTH:0] r_wptr;
    logic [ADDR_WIDTH:0] r_rptr;
    logic                r_head_valid;
    logic                r_overflow;
    logic                r_underflow;

    logic [ADDR_WIDTH:0] w_ram_cnt;
    logic [ADDR_WIDTH:0] w_count;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_ram_re;

    // Extra pointer MSB disambiguates full (DEPTH) from empty (0).
    assign w_ram_cnt = r_wptr - r_rptr;
    assign w_full    = (w_ram_cnt == DEPTH_V);
    assign w_push    = wr_en & ~w_full;
    assign w_pop     = rd_en & r_head_valid;
    // Refill the RAM output register whenever the head slot is free or being vacated.
    assign w_ram_re  = ~rst & (w_ram_cnt != '0) & (~r_head_valid | w_pop);
    assign w_count   = w_ram_cnt + {{ADDR_WIDTH{1'b0}}, r_head_valid};

    assign full        = w_full;
    assign empty       = ~r_head_valid;
    assign count       = w_count;
    assign almost_full = ({1'b0, w_count} >= AFULL_V);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign rd_data     = ram_dout;

    assign ram_we    = w_push & ~rst;
    assign ram_waddr = r_wptr[ADDR_WIDTH-1:0];
    assign ram_din   = wr_data;
    assign ram_re    = w_ram_re;
    assign ram_raddr = r_rptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_head_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_ram_re) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_ram_re) begin
                r_head_valid <= 1'b1;
            end else if (w_pop) begin
                r_head_valid <= 1'b0;
            end
            if (wr_en & w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en & ~r_head_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - scoreboard bench for sync_fifo_ctrl with a queue-based reference model
module tb_sync_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full, almost_full, empty, overflow, underflow, ram_we, ram_re;
    logic [DW-1:0] rd_data, ram_din;
    logic [AW:0]   count;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] mem [DEPTH];

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // External RAM: registered read data, updated only when ram_re is high.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    bit  m_hv, m_ovf, m_unf, m_push, m_pop, m_re;
    int  m_wptr, m_rptr, m_ramcnt;
    bit  e_empty, e_full, e_afull, e_ovf, e_unf, e_we, e_re;
    int  e_count, e_waddr, e_raddr;
    bit  armed = 1'b0;
    int  checks = 0;
    int  errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cycle(input bit r_st, input bit w, input logic [DW-1:0] d, input bit r);
        rst = r_st; wr_en = w; wr_data = d; rd_en = r;
        m_ramcnt = mq.size() - int'(m_hv);
        m_push   = w && (m_ramcnt != DEPTH) && !r_st;
        m_pop    = r && m_hv;
        m_re     = !r_st && (m_ramcnt != 0) && (!m_hv || m_pop);
        e_empty  = !m_hv;
        e_count  = mq.size();
        e_full   = (m_ramcnt == DEPTH);
        e_afull  = (e_count >= AFULL);
        e_ovf    = m_ovf;
        e_unf    = m_unf;
        e_we     = m_push;
        e_re     = m_re;
        e_waddr  = m_wptr % DEPTH;
        e_raddr  = m_rptr % DEPTH;
        if (m_push) exp_q.push_back(d);
        @(posedge clk);
        if (r_st) begin
            mq.delete(); exp_q.delete();
            m_hv = 0; m_ovf = 0; m_unf = 0; m_wptr = 0; m_rptr = 0;
        end else begin
            if (w && m_ramcnt == DEPTH) m_ovf = 1;
            if (r && !m_hv) m_unf = 1;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(d);
                m_wptr = (m_wptr + 1) % (2 * DEPTH);
            end
            if (m_re) m_rptr = (m_rptr + 1) % (2 * DEPTH);
            if (m_re) m_hv = 1;
            else if (m_pop) m_hv = 0;
        end
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("empty", 64'(empty), 64'(e_empty));
                chk("count", 64'(count), 64'(e_count));
                chk("full", 64'(full), 64'(e_full));
                chk("almost_full", 64'(almost_full), 64'(e_afull));
                chk("overflow", 64'(overflow), 64'(e_ovf));
                chk("underflow", 64'(underflow), 64'(e_unf));
                chk("ram_we", 64'(ram_we), 64'(e_we));
                chk("ram_re", 64'(ram_re), 64'(e_re));
                if (e_we) chk("ram_waddr", 64'(ram_waddr), 64'(e_waddr));
                if (e_re) chk("ram_raddr", 64'(ram_raddr), 64'(e_raddr));
                if (rd_en && !empty && !rst) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_no_data: got %0h expected none at %0t", rd_data, $time);
                    end else begin
                        chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        cycle(1, 0, '0, 0);
        armed = 1'b1;
        cycle(1, 0, '0, 0);
        cycle(0, 0, '0, 0);
        // latency into an empty FIFO
        cycle(0, 1, 32'hA1, 0);
        repeat (3) cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        // fill past capacity, then drain
        for (int i = 1; i <= 6; i++) cycle(0, 1, DW'(i), 0);
        repeat (7) cycle(0, 0, '0, 1);
        // streaming with rd_en held
        for (int i = 0; i < 40; i++) cycle(0, 1, DW'(i), 1);
        repeat (4) cycle(0, 0, '0, 1);
        // underflow then recovery
        cycle(0, 0, '0, 1);
        cycle(0, 1, 32'h55, 0);
        repeat (2) cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        // reset with three words held
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'hE0 + DW'(i), 0);
        repeat (2) cycle(0, 0, '0, 0);
        cycle(1, 0, '0, 1);
        cycle(0, 1, 32'h77, 0);
        repeat (2) cycle(0, 0, '0, 0);
        cycle(0, 0, '0, 1);
        // randomized phases with varied push/pop bias
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 600; i++) begin
                cycle(($urandom_range(0, 249) == 0),
                      ($urandom_range(0, 99) < (p == 0 ? 75 : (p == 1 ? 35 : 60))),
                      DW'($urandom),
                      ($urandom_range(0, 99) < (p == 0 ? 30 : (p == 1 ? 80 : 60))));
            end
        end
        repeat (8) cycle(0, 0, '0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
